fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with flush, and halt detection. Halt is detected on the memory's end-of-program halt word.
- Memory read is combinational: the instruction for the address driven in cycle N is valid in the same cycle N.

---
 rtl/mips_pkg.sv | 13 +
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hB422_1820;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, hold freezes, load captures a fetched word.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] inst,
  input  logic [31:0] pc4,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  // Flush beats hold so a redirect can clear a stalled slot; pc4 is left as-is on a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_inst  <= NOP_WORD;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if_id_inst  <= NOP_WORD;
      if_id_valid <= 1'b0;
    end else if (!hold && load) begin
      if_id_inst  <= inst;
      if_id_pc4   <= pc4;
      if_id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, redirect/stall priority, halt FSM and the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD,
  parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_addr,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  import mips_pkg::fetch_state_t;
  import mips_pkg::RUN;
  import mips_pkg::HALTED;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc4;
  logic         redirect;
  logic         flush;
  logic         hold;
  logic         load;

  assign inst_addr = pc;
  assign pc4       = pc + 32'd4;
  assign redirect  = branch_taken | jump_taken;

  // A halted fetch drains the halt word into decode, then keeps issuing bubbles.
  always_comb begin
    flush = redirect | ((state == HALTED) & ~stall);
    hold  = ~flush & stall;
    load  = ~flush & ~stall & (state == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      halted      <= 1'b0;
      fetch_count <= 32'h0;
    end else if (branch_taken) begin
      pc     <= {branch_target[31:2], 2'b00};
      state  <= RUN;
      halted <= 1'b0;
    end else if (jump_taken) begin
      pc     <= {jump_target[31:2], 2'b00};
      state  <= RUN;
      halted <= 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          fetch_count <= fetch_count + 32'd1;
          if (inst_in == HALT_WORD) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            pc <= pc4;
          end
        end
        HALTED: begin
          pc <= pc;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .hold        (hold),
    .load        (load),
    .inst        (inst_in),
    .pc4         (pc4),
    .if_id_inst  (if_id_inst),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small combinational instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic [31:0] inst_in;
  logic [31:0] inst_addr;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] HALT = 32'hB422_1820;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_taken    (jump_taken),
    .jump_target   (jump_target),
    .inst_in       (inst_in),
    .inst_addr     (inst_addr),
    .if_id_inst    (if_id_inst),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Memory: two fixed words at 0/4, halt word at 0x68, otherwise 0x2000_0000 | address.
  always_comb begin
    case (inst_addr)
      32'h0000_0000: inst_in = 32'h2010_0000;
      32'h0000_0004: inst_in = 32'h2008_0000;
      32'h0000_0068: inst_in = HALT;
      default:       inst_in = 32'h2000_0000 | inst_addr;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump_taken = 1'b0; jump_target = 32'h0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    chk("rst_addr",  inst_addr, 32'h0);
    chk("rst_inst",  if_id_inst, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_halt",  {31'h0, halted}, 32'h0);
    chk("rst_cnt",   fetch_count, 32'h0);

    step();
    chk("f1_addr", inst_addr, 32'h4);
    chk("f1_inst", if_id_inst, 32'h2010_0000);
    chk("f1_pc4",  if_id_pc4, 32'h4);
    chk("f1_valid", {31'h0, if_id_valid}, 32'h1);
    chk("f1_cnt",  fetch_count, 32'd1);
    step();
    chk("f2_addr", inst_addr, 32'h8);
    chk("f2_inst", if_id_inst, 32'h2008_0000);
    chk("f2_pc4",  if_id_pc4, 32'h8);
    chk("f2_cnt",  fetch_count, 32'd2);

    stall = 1'b1;
    step(); step();
    chk("st_addr", inst_addr, 32'h8);
    chk("st_inst", if_id_inst, 32'h2008_0000);
    chk("st_pc4",  if_id_pc4, 32'h8);
    chk("st_cnt",  fetch_count, 32'd2);
    stall = 1'b0;
    step();
    chk("rel_addr", inst_addr, 32'hC);
    chk("rel_inst", if_id_inst, 32'h2000_0008);
    chk("rel_pc4",  if_id_pc4, 32'hC);
    chk("rel_cnt",  fetch_count, 32'd3);

    // branch beats stall and jump
    branch_taken = 1'b1; branch_target = 32'h14;
    jump_taken = 1'b1; jump_target = 32'h64; stall = 1'b1;
    step();
    branch_taken = 1'b0; jump_taken = 1'b0; stall = 1'b0;
    chk("br_addr",  inst_addr, 32'h14);
    chk("br_valid", {31'h0, if_id_valid}, 32'h0);
    chk("br_inst",  if_id_inst, 32'h0);
    chk("br_cnt",   fetch_count, 32'd3);

    // jump with misaligned target: low bits dropped
    jump_taken = 1'b1; jump_target = 32'h66;
    step();
    jump_taken = 1'b0;
    chk("jmp_addr",  inst_addr, 32'h64);
    chk("jmp_valid", {31'h0, if_id_valid}, 32'h0);
    step();
    chk("j64_addr", inst_addr, 32'h68);
    chk("j64_inst", if_id_inst, 32'h2000_0064);
    chk("j64_cnt",  fetch_count, 32'd4);

    // halt word at 0x68
    step();
    chk("h_inst",  if_id_inst, HALT);
    chk("h_pc4",   if_id_pc4, 32'h6C);
    chk("h_valid", {31'h0, if_id_valid}, 32'h1);
    chk("h_halt",  {31'h0, halted}, 32'h1);
    chk("h_addr",  inst_addr, 32'h68);
    chk("h_cnt",   fetch_count, 32'd5);
    step();
    chk("hb_valid", {31'h0, if_id_valid}, 32'h0);
    chk("hb_inst",  if_id_inst, 32'h0);
    chk("hb_addr",  inst_addr, 32'h68);
    chk("hb_cnt",   fetch_count, 32'd5);
    chk("hb_halt",  {31'h0, halted}, 32'h1);

    // branch out of HALTED
    branch_taken = 1'b1; branch_target = 32'h20;
    step();
    branch_taken = 1'b0;
    chk("hr_halt", {31'h0, halted}, 32'h0);
    chk("hr_addr", inst_addr, 32'h20);
    step();
    chk("hr2_addr", inst_addr, 32'h24);
    chk("hr2_inst", if_id_inst, 32'h2000_0020);
    chk("hr2_pc4",  if_id_pc4, 32'h24);
    chk("hr2_cnt",  fetch_count, 32'd6);

    // redirect in the same cycle the halt word is seen: halt discarded
    jump_taken = 1'b1; jump_target = 32'h68;
    step();
    jump_taken = 1'b0;
    chk("rh_addr0", inst_addr, 32'h68);
    branch_taken = 1'b1; branch_target = 32'h30;
    step();
    branch_taken = 1'b0;
    chk("rh_addr",  inst_addr, 32'h30);
    chk("rh_halt",  {31'h0, halted}, 32'h0);
    chk("rh_cnt",   fetch_count, 32'd6);
    chk("rh_valid", {31'h0, if_id_valid}, 32'h0);

    // halt again, then stall keeps the halt word in IF/ID
    jump_taken = 1'b1; jump_target = 32'h68;
    step();
    jump_taken = 1'b0;
    step();
    chk("h2_halt", {31'h0, halted}, 32'h1);
    chk("h2_cnt",  fetch_count, 32'd7);
    stall = 1'b1;
    step();
    chk("hs_inst",  if_id_inst, HALT);
    chk("hs_valid", {31'h0, if_id_valid}, 32'h1);
    stall = 1'b0;
    step();
    chk("hs2_valid", {31'h0, if_id_valid}, 32'h0);

    // async reset mid-cycle while halted
    #2 reset = 1'b1;
    #1;
    chk("ar_addr",  inst_addr, 32'h0);
    chk("ar_inst",  if_id_inst, 32'h0);
    chk("ar_pc4",   if_id_pc4, 32'h0);
    chk("ar_valid", {31'h0, if_id_valid}, 32'h0);
    chk("ar_halt",  {31'h0, halted}, 32'h0);
    chk("ar_cnt",   fetch_count, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // PC wrap at top of address space
    jump_taken = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump_taken = 1'b0;
    chk("wr_addr0", inst_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_addr", inst_addr, 32'h0);
    chk("wr_pc4",  if_id_pc4, 32'h0);
    chk("wr_inst", if_id_inst, 32'hFFFF_FFFC);
    chk("wr_cnt",  fetch_count, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
